// File: rtl/accumulator_lane_adder.sv
// accumulator_lane_adder
//   Combinational sum of the LANES samples of one input beat. Kept separate
//   from the frame accumulator so it can later be swapped for a deeper,
//   pipelined adder tree without touching the frame logic.
// Ports:
//   in_data  : LANES packed samples, lane k at [k*DATA_W +: DATA_W]
//   lane_sum : sum of all lanes, DATA_W + clog2(LANES) bits wide
//              (sign-extended lanes when SIGNED = 1, zero-extended otherwise)
module accumulator_lane_adder #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int SIGNED = 0
) (
  input  logic [LANES*DATA_W-1:0]         in_data,
  output logic [DATA_W+$clog2(LANES)-1:0] lane_sum
);

  localparam int LSUM_W = DATA_W + $clog2(LANES);

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (SIGNED != 0) begin
        lane_sum = lane_sum + LSUM_W'($signed(in_data[k*DATA_W +: DATA_W]));
      end else begin
        lane_sum = lane_sum + LSUM_W'(in_data[k*DATA_W +: DATA_W]);
      end
    end
  end

endmodule

// File: rtl/accumulator_frame.sv
// accumulator_frame
//   Streaming frame accumulator. Sums FRAME_LEN samples arriving LANES per
//   beat and emits one total per frame, with a flag that records whether
//   the result range was exceeded at any step of that frame.
//   Two stages: stage 1 registers the per-beat lane sum, stage 2 folds it
//   into the running total and loads the output register on the last beat.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   clear         : synchronous discard of the partial frame
//   in_valid/in_ready/in_data    : input beat handshake
//   out_valid/out_ready          : result handshake
//   out_sum, out_overflow        : frame total and its range-exceeded flag
module accumulator_frame #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 1024,
  parameter int SUM_W     = 32,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SUM_W-1:0]        out_sum,
  output logic                    out_overflow
);

  localparam int BEATS  = FRAME_LEN / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSUM_W = DATA_W + $clog2(LANES);
  // Two guard bits above the wider operand so the sum never loses its
  // true sign/magnitude before the range check.
  localparam int EXT_W  = ((SUM_W > LSUM_W) ? SUM_W : LSUM_W) + 2;

  if (BEATS < 2 || (FRAME_LEN % LANES) != 0) begin : g_bad_frame
    $error("accumulator_frame: FRAME_LEN must be a multiple of LANES with at least 2 beats");
  end
  if (LANES < 1 || LANES > 8 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("accumulator_frame: LANES must be a power of two in 1..8");
  end
  if (SUM_W < DATA_W) begin : g_bad_sum
    $error("accumulator_frame: SUM_W must be >= DATA_W");
  end

  logic              adv;
  logic              is_last;
  logic [CNT_W-1:0]  cnt;
  logic [LSUM_W-1:0] lane_sum;

  logic              s1_valid;
  logic [LSUM_W-1:0] s1_sum;
  logic              s1_first;
  logic              s1_last;

  logic [SUM_W-1:0]  acc;
  logic              ovf_flag;

  logic [SUM_W-1:0]  base;
  logic [EXT_W-1:0]  base_x;
  logic [EXT_W-1:0]  lsum_x;
  logic [EXT_W-1:0]  next_x;
  logic [SUM_W-1:0]  smin;
  logic [SUM_W-1:0]  clamp_val;
  logic [SUM_W-1:0]  acc_next;
  logic              oor;
  logic              flag_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign is_last  = (cnt == CNT_W'(BEATS - 1));

  accumulator_lane_adder #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SIGNED (SIGNED)
  ) u_lane_adder (
    .in_data  (in_data),
    .lane_sum (lane_sum)
  );

  always_comb begin
    base      = s1_first ? '0 : acc;
    smin      = '0;
    smin[SUM_W-1] = 1'b1;
    if (SIGNED != 0) begin
      base_x = EXT_W'($signed(base));
      lsum_x = EXT_W'($signed(s1_sum));
    end else begin
      base_x = EXT_W'(base);
      lsum_x = EXT_W'(s1_sum);
    end
    next_x = base_x + lsum_x;
    if (SIGNED != 0) begin
      // In range only while every bit above the result sign bit copies it.
      oor       = (next_x[EXT_W-1:SUM_W-1] != '0) && (next_x[EXT_W-1:SUM_W-1] != '1);
      clamp_val = next_x[EXT_W-1] ? smin : ~smin;
    end else begin
      oor       = (next_x[EXT_W-1:SUM_W] != '0);
      clamp_val = '1;
    end
    acc_next  = (SATURATE != 0 && oor) ? clamp_val : next_x[SUM_W-1:0];
    flag_next = (s1_first ? 1'b0 : ovf_flag) | oor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      acc          <= '0;
      ovf_flag     <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // clear leaves a pending result untouched; only the partial frame goes.
      if (clear) begin
        cnt      <= '0;
        s1_valid <= 1'b0;
        acc      <= '0;
        ovf_flag <= 1'b0;
      end else if (adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum   <= lane_sum;
          s1_first <= (cnt == '0);
          s1_last  <= is_last;
          cnt      <= is_last ? '0 : cnt + 1'b1;
        end
        if (s1_valid) begin
          acc      <= acc_next;
          ovf_flag <= flag_next;
          // Placed after the handshake clear so a new result wins that edge.
          if (s1_last) begin
            out_valid    <= 1'b1;
            out_sum      <= acc_next;
            out_overflow <= flag_next;
          end
        end
      end
    end
  end

endmodule
